// File: rtl/button_ctrl_if.sv
// ---------------------------------------------------------------------------
// button_ctrl_if
//   Register bus between a bus master and the button controller.
//   Ports (signals):
//     addr   [31:0]  byte address, master -> controller
//     we             one-cycle write strobe, master -> controller
//     wdata  [31:0]  write data, master -> controller
//     rdata  [31:0]  registered read data, controller -> master
//     irq            level interrupt, controller -> master
// ---------------------------------------------------------------------------
interface button_ctrl_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/button_ctrl.sv
// ---------------------------------------------------------------------------
// button_ctrl
//   Memory-mapped controller for N_BTN push-buttons. Every raw pin is brought
//   into the clk domain by a two-flop synchroniser, then debounced by a
//   per-channel stability counter. Edges of the debounced level are latched
//   into a write-1-to-clear pending register, and enabled pending bits drive a
//   registered level interrupt.
//
//   Register map (byte addresses):
//     BASE_ADDR      LEVEL  (RO)   debounced button levels
//     BASE_ADDR + 4  PEND   (W1C)  latched edges
//     BASE_ADDR + 8  IE     (RW)   interrupt enables
//
//   Ports:
//     clk     system clock
//     rst_n   asynchronous active-low reset
//     button  raw button pins, asynchronous to clk
//     bus     register bus (slave side): addr, we, wdata in; rdata, irq out
// ---------------------------------------------------------------------------
module button_ctrl #(
  parameter int unsigned N_BTN     = 5,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F078,
  parameter logic [19:0] DB_CYCLES = 20'd1000000,
  parameter logic [1:0]  EDGE_MODE = 2'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button,
  button_ctrl_if.slave     bus
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int unsigned CW = $clog2(int'(DB_CYCLES) + 1);

  // A change is accepted on the cycle the counter has already seen
  // DB_CYCLES-1 consecutive differing samples, i.e. on the DB_CYCLES-th one.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 20'd1);

  localparam logic [31:0] ADDR_LEVEL = BASE_ADDR;
  localparam logic [31:0] ADDR_PEND  = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_IE    = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Encoding 3 is not a real mode and falls back to rising-edge detection.
  localparam edge_mode_e MODE = (EDGE_MODE == 2'd1) ? EDGE_FALL :
                                (EDGE_MODE == 2'd2) ? EDGE_BOTH : EDGE_RISE;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q,  level_d;
  logic [N_BTN-1:0] level_prev_q;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] pend_q,   pend_d;
  logic [N_BTN-1:0] ie_q,     ie_d;
  logic [31:0]      rdata_q,  rdata_d;
  logic             irq_q,    irq_d;

  // -------------------------------------------------------------------------
  // Debounce: a channel's level follows sync2 only after the two have
  // differed for DB_CYCLES consecutive samples; any agreement restarts.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    level_d = level_q;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Edge detection on the debounced level
  // -------------------------------------------------------------------------
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] set;

  assign rise = level_q & ~level_prev_q;
  assign fall = ~level_q & level_prev_q;

  always_comb begin
    set = rise;
    unique case (MODE)
      EDGE_RISE: set = rise;
      EDGE_FALL: set = fall;
      EDGE_BOTH: set = rise | fall;
      default:   set = rise;
    endcase
  end

  // -------------------------------------------------------------------------
  // Register writes
  // -------------------------------------------------------------------------
  logic             wr_pend;
  logic             wr_ie;
  logic [N_BTN-1:0] clr;

  assign wr_pend = bus.we && (bus.addr == ADDR_PEND);
  assign wr_ie   = bus.we && (bus.addr == ADDR_IE);
  assign clr     = wr_pend ? bus.wdata[N_BTN-1:0] : '0;

  // Set is OR-ed in after the clear, so an edge arriving in the same cycle
  // as its W1C is never lost.
  assign pend_d = (pend_q & ~clr) | set;
  assign ie_d   = wr_ie ? bus.wdata[N_BTN-1:0] : ie_q;

  // Interrupt looks at next-state values so it tracks pend/ie with exactly
  // one cycle of latency from the causing edge or write.
  assign irq_d = |(pend_d & ie_d);

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  // -------------------------------------------------------------------------
  // Read mux: loads only on an address hit and otherwise holds. Uses the
  // current (pre-write) register values, so a same-cycle read and write of
  // one register returns the old contents.
  // -------------------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    if (bus.addr == ADDR_LEVEL) begin
      rdata_d = 32'(level_q);
    end else if (bus.addr == ADDR_PEND) begin
      rdata_d = 32'(pend_q);
    end else if (bus.addr == ADDR_IE) begin
      rdata_d = 32'(ie_q);
    end
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      // NOTE: the counter array is a small bank of flops rather than a RAM,
      // and it must be reset so that a reset mid-debounce discards partial
      // counts.
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
      pend_q       <= '0;
      ie_q         <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // pre-edge value of the others (sync1 -> sync2 stays a true 2-flop
      // chain regardless of statement order).
      sync1_q      <= button;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pend_q       <= pend_d;
      ie_q         <= ie_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule
